rossler_euler: RTL and testbench

Fixed-point Rössler attractor solver that consumes the system constant bank (a, b, c, h, x0, y0, z0) and integrates the system with forward Euler. It uses one shared multiplier, finishes one iteration every 5 cycles, and presents (x, y, z) with a valid strobe to the downstream DAC/serial streaming logic. Number format is signed Q10.21 (1 sign, 10 integer, 21 fraction bits), the same format as the constant bank.

---
 rtl/rossler_pkg.sv | 35 +++
 rtl/fxp_mult.sv | 29 ++
 rtl/rossler_euler.sv | 164 ++++++++++++++++
 tb/tb_rossler_euler.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/rossler_pkg.sv
`default_nettype none
// ============================================================================
// Module      : rossler_pkg
// Description : Shared definitions for the Rossler Euler solver: default
//               fixed-point format, FSM state encoding and handy constants.
// Revision    : 1.0 - initial release
// ============================================================================
package rossler_pkg;

  // Default Q10.21 word format
  localparam int RP_WIDTH = 32;
  localparam int RP_FRAC  = 21;

  // FSM state encoding, one multiply issued per non-idle state
  localparam logic [2:0] c_st_idle  = 3'd0;
  localparam logic [2:0] c_st_m_ay  = 3'd1;
  localparam logic [2:0] c_st_m_zxc = 3'd2;
  localparam logic [2:0] c_st_m_hx  = 3'd3;
  localparam logic [2:0] c_st_m_hy  = 3'd4;
  localparam logic [2:0] c_st_m_hz  = 3'd5;

  typedef enum logic [2:0] {
    S_IDLE  = c_st_idle,
    S_M_AY  = c_st_m_ay,
    S_M_ZXC = c_st_m_zxc,
    S_M_HX  = c_st_m_hx,
    S_M_HY  = c_st_m_hy,
    S_M_HZ  = c_st_m_hz
  } state_t;

  // Fixed-point 1.0 in Q10.21
  localparam logic [RP_WIDTH-1:0] c_fxp_one = 32'h0020_0000;

endpackage
`default_nettype wire

// File: rtl/fxp_mult.sv
`default_nettype none
// ============================================================================
// Module      : fxp_mult
// Description : Combinational signed fixed-point multiply. The full-width
//               product is shifted right arithmetically by FRAC (rounding
//               toward -inf) and the low WIDTH bits are kept (wrapping).
// Revision    : 1.0 - initial release
// ============================================================================
module fxp_mult #(
  parameter int WIDTH = 32,
  parameter int FRAC  = 21
) (
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  output logic [WIDTH-1:0] o_p
);

  // Sign-extend both operands so the product is formed at double width
  logic signed [2*WIDTH-1:0] w_a_ext;
  logic signed [2*WIDTH-1:0] w_b_ext;

  assign w_a_ext = {{WIDTH{i_a[WIDTH-1]}}, i_a};
  assign w_b_ext = {{WIDTH{i_b[WIDTH-1]}}, i_b};

  // Scale back to the word format and keep the low word (wraps on overflow)
  assign o_p = WIDTH'((w_a_ext * w_b_ext) >>> FRAC);

endmodule
`default_nettype wire

// File: rtl/rossler_euler.sv
`default_nettype none
// ============================================================================
// Module      : rossler_euler
// Description : Forward-Euler integrator for the Rossler system in signed
//               fixed point. One shared multiplier, one iteration every five
//               cycles; each new (x, y, z) is flagged by valid_o.
// Revision    : 1.0 - initial release
// ============================================================================
module rossler_euler
  import rossler_pkg::*;
#(
  parameter int WIDTH = RP_WIDTH,
  parameter int FRAC  = RP_FRAC
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             start_i,
  input  logic             stop_i,
  input  logic [15:0]      steps_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic [WIDTH-1:0] c_i,
  input  logic [WIDTH-1:0] h_i,
  input  logic [WIDTH-1:0] x0_i,
  input  logic [WIDTH-1:0] y0_i,
  input  logic [WIDTH-1:0] z0_i,
  output logic [WIDTH-1:0] x_o,
  output logic [WIDTH-1:0] y_o,
  output logic [WIDTH-1:0] z_o,
  output logic             valid_o,
  output logic             busy_o,
  output logic             done_o
);

  state_t r_state;
  state_t w_next;

  // Constants latched at start, stable for the whole run
  logic [WIDTH-1:0] r_a, r_b, r_c, r_h;
  logic [15:0]      r_steps;
  logic [15:0]      r_cnt;
  logic             r_stop_pend;

  // Integrator state and intermediate products
  logic [WIDTH-1:0] r_x, r_y, r_z;
  logic [WIDTH-1:0] r_p_ay, r_p_zxc;
  logic [WIDTH-1:0] r_nx, r_ny;
  logic             r_valid, r_done;

  // Combinational datapath terms
  logic [WIDTH-1:0] w_neg_yz, w_x_c, w_dy, w_dz;
  logic [WIDTH-1:0] w_mul_a, w_mul_b, w_prod;
  logic             w_last;

  assign w_neg_yz = (~r_y + 1'b1) - r_z;
  assign w_x_c    = r_x - r_c;
  assign w_dy     = r_x + r_p_ay;
  assign w_dz     = r_b + r_p_zxc;

  // Run ends after this iteration on count reached or a stop request
  // (stop_i seen on the final cycle is folded in so it is not lost)
  assign w_last = (r_state == S_M_HZ) &&
                  (((r_steps != 16'd0) && ((r_cnt + 16'd1) == r_steps)) ||
                   r_stop_pend || stop_i);

  // Select the operand pair for the single shared multiplier
  always_comb begin
    w_mul_a = '0;
    w_mul_b = '0;
    case (r_state)
      S_M_AY:  begin w_mul_a = r_a; w_mul_b = r_y;      end
      S_M_ZXC: begin w_mul_a = r_z; w_mul_b = w_x_c;    end
      S_M_HX:  begin w_mul_a = r_h; w_mul_b = w_neg_yz; end
      S_M_HY:  begin w_mul_a = r_h; w_mul_b = w_dy;     end
      S_M_HZ:  begin w_mul_a = r_h; w_mul_b = w_dz;     end
      default: ;
    endcase
  end

  fxp_mult #(
    .WIDTH (WIDTH),
    .FRAC  (FRAC)
  ) u_mult (
    .i_a (w_mul_a),
    .i_b (w_mul_b),
    .o_p (w_prod)
  );

  // FSM state register
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) r_state <= S_IDLE;
    else         r_state <= w_next;
  end

  // FSM next-state: fixed five-state loop, exit decided in M_HZ
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (start_i) w_next = S_M_AY;
      S_M_AY:  w_next = S_M_ZXC;
      S_M_ZXC: w_next = S_M_HX;
      S_M_HX:  w_next = S_M_HY;
      S_M_HY:  w_next = S_M_HZ;
      S_M_HZ:  w_next = w_last ? S_IDLE : S_M_AY;
      default: w_next = S_IDLE;
    endcase
  end

  // Datapath: latch at start, accumulate products, commit state in M_HZ
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_a <= '0; r_b <= '0; r_c <= '0; r_h <= '0;
      r_steps     <= '0;
      r_cnt       <= '0;
      r_stop_pend <= 1'b0;
      r_x <= '0; r_y <= '0; r_z <= '0;
      r_p_ay <= '0; r_p_zxc <= '0;
      r_nx <= '0; r_ny <= '0;
      r_valid <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_valid <= 1'b0;
      r_done  <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start_i) begin
            r_a <= a_i; r_b <= b_i; r_c <= c_i; r_h <= h_i;
            r_steps     <= steps_i;
            r_cnt       <= '0;
            r_stop_pend <= 1'b0;
            r_x <= x0_i; r_y <= y0_i; r_z <= z0_i;
          end
        end
        S_M_AY:  r_p_ay  <= w_prod;
        S_M_ZXC: r_p_zxc <= w_prod;
        S_M_HX:  r_nx    <= r_x + w_prod;
        S_M_HY:  r_ny    <= r_y + w_prod;
        S_M_HZ: begin
          r_x     <= r_nx;
          r_y     <= r_ny;
          r_z     <= r_z + w_prod;
          r_cnt   <= r_cnt + 16'd1;
          r_valid <= 1'b1;
          r_done  <= w_last;
        end
        default: ;
      endcase
      // Stop requests are remembered only while a run is active
      if (r_state != S_IDLE) begin
        if (w_last)      r_stop_pend <= 1'b0;
        else if (stop_i) r_stop_pend <= 1'b1;
      end
    end
  end

  assign x_o     = r_x;
  assign y_o     = r_y;
  assign z_o     = r_z;
  assign valid_o = r_valid;
  assign done_o  = r_done;
  assign busy_o  = (r_state != S_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_rossler_euler.sv
`default_nettype none
// ============================================================================
// Module      : tb_rossler_euler
// Description : Scoreboard bench for rossler_euler. Runs are computed with a
//               plain-arithmetic Q10.21 Euler model; a monitor pops expected
//               states whenever valid_o is seen.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_rossler_euler;
  import rossler_pkg::*;

  logic        clk = 1'b0;
  logic        rst_ni, start_i, stop_i;
  logic [15:0] steps_i;
  logic [31:0] a_i, b_i, c_i, h_i, x0_i, y0_i, z0_i;
  logic [31:0] x_o, y_o, z_o;
  logic        valid_o, busy_o, done_o;

  int cyc = 0;
  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [31:0] x;
    logic [31:0] y;
    logic [31:0] z;
    logic        done;
    int          cyc;
  } exp_t;

  exp_t sb[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  rossler_euler dut (
    .clk_i   (clk),
    .rst_ni  (rst_ni),
    .start_i (start_i),
    .stop_i  (stop_i),
    .steps_i (steps_i),
    .a_i     (a_i),
    .b_i     (b_i),
    .c_i     (c_i),
    .h_i     (h_i),
    .x0_i    (x0_i),
    .y0_i    (y0_i),
    .z0_i    (z0_i),
    .x_o     (x_o),
    .y_o     (y_o),
    .z_o     (z_o),
    .valid_o (valid_o),
    .busy_o  (busy_o),
    .done_o  (done_o)
  );

  // Q10.21 product: exact 64-bit product, floor-divide by 2^21, wrap to 32
  function automatic logic [31:0] fmul(input logic [31:0] p, input logic [31:0] q);
    longint prod;
    prod = longint'($signed(p)) * longint'($signed(q));
    prod = prod >>> 21;
    return prod[31:0];
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic monitor();
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst_ni === 1'b1) begin
        if (valid_o === 1'b1) begin
          if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_valid: got valid at cycle %0d expected none", cyc);
          end else begin
            e = sb.pop_front();
            chk("x", x_o, e.x);
            chk("y", y_o, e.y);
            chk("z", z_o, e.z);
            chk("done", {31'b0, done_o}, {31'b0, e.done});
            chk("valid_cycle", cyc, e.cyc);
          end
        end else if (done_o === 1'b1) begin
          checks++;
          errors++;
          $display("FAIL stray_done: got done without valid at cycle %0d expected none", cyc);
        end
      end
    end
  endtask

  // Issue one run; must be called at a falling edge.
  // stop_at > 0: stop_i sampled at start edge + stop_at.
  task automatic run(input logic [31:0] a, input logic [31:0] b, input logic [31:0] c,
                     input logic [31:0] h, input logic [31:0] x0, input logic [31:0] y0,
                     input logic [31:0] z0, input logic [15:0] steps,
                     input int stop_at, input bit restart);
    int k, n, lim;
    logic [31:0] x, y, z, nx, ny, nz;
    exp_t e;
    lim = 0;
    while (busy_o === 1'b1 && lim < 200) begin @(negedge clk); lim++; end
    if (busy_o === 1'b1) begin
      checks++; errors++;
      $display("FAIL idle_wait: got busy=1 expected 0");
    end
    a_i = a; b_i = b; c_i = c; h_i = h;
    x0_i = x0; y0_i = y0; z0_i = z0; steps_i = steps;
    start_i = 1'b1;
    @(posedge clk); #1;
    start_i = 1'b0;
    k = cyc;
    chk("busy_start", {31'b0, busy_o}, 32'd1);
    chk("x_start", x_o, x0);
    chk("y_start", y_o, y0);
    chk("z_start", z_o, z0);

    // Number of iterations the run must produce
    if (steps == 16'd0) n = (stop_at + 4) / 5;
    else begin
      n = int'(steps);
      if (stop_at > 0 && (stop_at + 4) / 5 < n) n = (stop_at + 4) / 5;
    end

    x = x0; y = y0; z = z0;
    for (int i = 1; i <= n; i++) begin
      nx = x + fmul(h, -y - z);
      ny = y + fmul(h, x + fmul(a, y));
      nz = z + fmul(h, b + fmul(z, x - c));
      x = nx; y = ny; z = nz;
      e.x = x; e.y = y; e.z = z; e.done = (i == n); e.cyc = k + 5 * i;
      sb.push_back(e);
    end

    // Inputs wander during the run; latched values must be used
    a_i = $urandom; b_i = $urandom; c_i = $urandom; h_i = $urandom;
    x0_i = $urandom; y0_i = $urandom; z0_i = $urandom; steps_i = 16'($urandom);

    if (restart) begin
      @(negedge clk);
      start_i = 1'b1;
      @(negedge clk);
      start_i = 1'b0;
    end

    if (stop_at > 0) begin
      while (cyc < k + stop_at - 1) @(negedge clk);
      stop_i = 1'b1;
      @(posedge clk); #1;
      stop_i = 1'b0;
    end

    lim = 0;
    while (sb.size() != 0 && lim < 5 * n + 20) begin @(negedge clk); lim++; end
    if (sb.size() != 0) begin
      checks++; errors++;
      $display("FAIL run_timeout: got %0d pending results expected 0", sb.size());
      sb.delete();
    end
    if (lim == 0) @(negedge clk);
    chk("busy_end", {31'b0, busy_o}, 32'd0);
  endtask

  localparam logic [31:0] c_nom_ab = 32'h0006_6666;
  localparam logic [31:0] c_nom_c  = 32'h00B6_6666;
  localparam logic [31:0] c_nom_h  = 32'h0000_0831;
  localparam logic [31:0] c_nom_s0 = 32'h0003_3333;

  initial begin
    int k;
    rst_ni = 1'b0; start_i = 1'b0; stop_i = 1'b0; steps_i = '0;
    a_i = '0; b_i = '0; c_i = '0; h_i = '0; x0_i = '0; y0_i = '0; z0_i = '0;
    repeat (3) @(negedge clk);
    chk("rst_x", x_o, 32'd0);
    chk("rst_valid", {31'b0, valid_o}, 32'd0);
    chk("rst_busy", {31'b0, busy_o}, 32'd0);
    chk("rst_done", {31'b0, done_o}, 32'd0);
    rst_ni = 1'b1;
    fork monitor(); join_none
    @(negedge clk);

    // Nominal single step
    run(c_nom_ab, c_nom_ab, c_nom_c, c_nom_h, c_nom_s0, c_nom_s0, c_nom_s0, 16'd1, 0, 1'b0);

    // Stop while idle is ignored; counted run of 3 follows back-to-back
    stop_i = 1'b1; @(negedge clk); stop_i = 1'b0;
    run(c_nom_ab, c_nom_ab, c_nom_c, c_nom_h, c_nom_s0, c_nom_s0, c_nom_s0, 16'd3, 0, 1'b0);

    // Long counted run
    run(c_nom_ab, c_nom_ab, c_nom_c, c_nom_h, c_nom_s0, c_nom_s0, c_nom_s0, 16'd1000, 0, 1'b0);

    // Free run stopped seven cycles in
    run(c_nom_ab, c_nom_ab, c_nom_c, c_nom_h, c_nom_s0, c_nom_s0, c_nom_s0, 16'd0, 7, 1'b0);

    // Stop coinciding with the final counted iteration
    run(c_nom_ab, c_nom_ab, c_nom_c, c_nom_h, c_nom_s0, c_nom_s0, c_nom_s0, 16'd2, 10, 1'b0);

    // Second start while busy is ignored
    run(c_nom_ab, c_nom_ab, c_nom_c, c_nom_h, 32'h0010_0000, c_nom_s0, 32'hFFF0_0000,
        16'd3, 0, 1'b1);

    // Wrap-around: -y-z wraps to zero, x stays put
    run(32'd0, 32'd0, 32'd0, c_fxp_one, 32'h0010_0000, 32'h8000_0000, 32'h8000_0000,
        16'd1, 0, 1'b0);
    chk("wrap_x1", x_o, 32'h0010_0000);

    // Asynchronous reset while in M_HX
    a_i = c_nom_ab; b_i = c_nom_ab; c_i = c_nom_c; h_i = c_nom_h;
    x0_i = c_nom_s0; y0_i = c_nom_s0; z0_i = c_nom_s0; steps_i = 16'd5;
    start_i = 1'b1;
    @(posedge clk); #1;
    start_i = 1'b0;
    k = cyc;
    @(posedge clk); @(posedge clk); #2;
    chk("pre_rst_busy", {31'b0, busy_o}, 32'd1);
    rst_ni = 1'b0;
    #1;
    chk("arst_x", x_o, 32'd0);
    chk("arst_y", y_o, 32'd0);
    chk("arst_z", z_o, 32'd0);
    chk("arst_busy", {31'b0, busy_o}, 32'd0);
    chk("arst_valid", {31'b0, valid_o}, 32'd0);
    @(negedge clk);
    rst_ni = 1'b1;
    @(negedge clk);
    run(c_nom_ab, c_nom_ab, c_nom_c, c_nom_h, c_nom_s0, c_nom_s0, c_nom_s0, 16'd2, 0, 1'b0);

    // Randomized runs
    for (int r = 0; r < 8; r++) begin
      logic [15:0] st;
      int sa;
      st = (r % 3 == 0) ? 16'd0 : 16'($urandom_range(1, 20));
      sa = (st == 16'd0) ? int'($urandom_range(3, 40))
                         : ((r % 2 == 0) ? int'($urandom_range(3, 60)) : 0);
      if (r < 4)
        run($urandom_range(0, 32'h0040_0000), $urandom_range(0, 32'h0040_0000),
            $urandom_range(0, 32'h0100_0000), $urandom_range(0, 32'h0000_4000),
            $urandom_range(0, 32'h0040_0000), $urandom_range(0, 32'h0040_0000),
            $urandom_range(0, 32'h0040_0000), st, sa, 1'b0);
      else
        run($urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom,
            st, sa, (r == 5));
    end

    repeat (10) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
